// File: rtl/dma_dsc_cache_ctrl.sv
// Descriptor cache controller: circular FIFO over an external SRAM with a
// registered-read pipeline and a single-entry output holding stage.
module dma_dsc_cache_ctrl #(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LATENCY = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  FLUSH,
  input  logic                  DSC_IN_VALID,
  output logic                  DSC_IN_READY,
  input  logic [WIDTH-1:0]      DSC_IN_DATA,
  output logic                  DSC_OUT_VALID,
  input  logic                  DSC_OUT_READY,
  output logic [WIDTH-1:0]      DSC_OUT_DATA,
  output logic                  DSC_OUT_ERR,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  RAM_WEN,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic [WIDTH-1:0]      RAM_WDATA,
  output logic                  RAM_REN,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR,
  input  logic [WIDTH-1:0]      RAM_RDATA,
  input  logic                  RAM_DB_DETECT
);

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      lat_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [WIDTH-1:0]      out_data_q;
  logic                  out_err_q;
  logic                  wr_fire, issue, capture, pop;

  assign FULL          = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign EMPTY         = (count_q == '0);
  assign COUNT         = count_q;
  assign DSC_IN_READY  = !FULL && !FLUSH;
  assign wr_fire       = DSC_IN_VALID && DSC_IN_READY;
  assign RAM_WEN       = wr_fire;
  assign RAM_WADDR     = wr_ptr_q;
  assign RAM_WDATA     = DSC_IN_DATA;
  assign RAM_REN       = issue;
  assign RAM_RADDR     = rd_ptr_q;
  assign DSC_OUT_VALID = (state_q == S_HOLD);
  assign DSC_OUT_DATA  = out_data_q;
  assign DSC_OUT_ERR   = out_err_q;

  // Read FSM next-state and strobes; FLUSH overrides every transition.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    pop     = 1'b0;
    case (state_q)
      // No entry is held in IDLE, so pending reduces to count_q.
      S_IDLE: if (count_q != '0) begin
        issue   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (lat_q == '0) begin
        capture = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (DSC_OUT_READY) begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (FLUSH) begin
      state_d = S_IDLE;
      issue   = 1'b0;
      capture = 1'b0;
      pop     = 1'b0;
    end
  end

  // FSM state and read-latency countdown.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (FLUSH)
        lat_q <= '0;
      else if (issue)
        lat_q <= LAT_W'(RD_LATENCY - 1);
      else if (state_q == S_WAIT && lat_q != '0)
        lat_q <= lat_q - 1'b1;
    end
  end

  // Ring pointers and occupancy count.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_fire, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output register: captures RAM data and error flag when the read lands.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else if (FLUSH) begin
      out_err_q  <= 1'b0;
    end else if (capture) begin
      out_data_q <= RAM_RDATA;
      out_err_q  <= RAM_DB_DETECT;
    end
  end

endmodule

// File: tb/tb_dma_dsc_cache_ctrl.sv
// Directed self-checking bench for dma_dsc_cache_ctrl with a 2-cycle SRAM model.
module tb_dma_dsc_cache_ctrl;
  localparam int WIDTH = 128;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int RDL   = 2;

  logic CLOCK = 1'b0, RESET_N = 1'b0, FLUSH = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, db_inject = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid, out_err, full, empty, ram_wen, ram_ren, db;
  logic [WIDTH-1:0] out_data, wdata, rdata;
  logic [AW:0] count;
  logic [AW-1:0] waddr, raddr, raddr_q;
  logic db_p1 = 1'b0, db_p2 = 1'b0;
  logic [WIDTH-1:0] mem [DEPTH];
  int n_cmp = 0, n_bad = 0;

  dma_dsc_cache_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .FLUSH(FLUSH),
    .DSC_IN_VALID(in_valid), .DSC_IN_READY(in_ready), .DSC_IN_DATA(in_data),
    .DSC_OUT_VALID(out_valid), .DSC_OUT_READY(out_ready), .DSC_OUT_DATA(out_data),
    .DSC_OUT_ERR(out_err), .COUNT(count), .FULL(full), .EMPTY(empty),
    .RAM_WEN(ram_wen), .RAM_WADDR(waddr), .RAM_WDATA(wdata),
    .RAM_REN(ram_ren), .RAM_RADDR(raddr), .RAM_RDATA(rdata), .RAM_DB_DETECT(db)
  );

  always #5 CLOCK = ~CLOCK;

  // SRAM model: address register then data register; error flag follows the same pipe.
  always @(posedge CLOCK) begin
    if (ram_wen) mem[waddr] <= wdata;
    if (ram_ren) raddr_q <= raddr;
    rdata <= mem[raddr_q];
    db_p1 <= ram_ren & db_inject;
    db_p2 <= db_p1;
  end
  assign db = db_p2;

  function automatic logic [WIDTH-1:0] dval(input int unsigned i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + i;
    return {w, ~w, w ^ 32'h5A5A_5A5A, i * 32'h0101_0101};
  endfunction

  task automatic step();
    @(negedge CLOCK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0; db_inject = 1'b0;
    step(); step();
    RESET_N = 1'b1;
  endtask

  task automatic wait_valid(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      #1;
      if (out_valid === 1'b1) begin got = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    step(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", out_err); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", full); end
    n_cmp++; if (ram_wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %b want 0", ram_wen); end
    n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL rst_ren: got %b want 0", ram_ren); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    step();
    RESET_N = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = dval(0); out_ready = 1'b0; #1;
    n_cmp++; if ({ram_wen, waddr} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL single_wr: got wen=%b addr=%0d want 1/0", ram_wen, waddr); end
    n_cmp++; if (wdata !== dval(0)) begin n_bad++; $display("FAIL single_wdata: got %h want %h", wdata, dval(0)); end
    n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL single_ren0: got %b want 0", ram_ren); end
    step(); in_valid = 1'b0; #1;
    n_cmp++; if ({ram_ren, raddr} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL single_rd: got ren=%b addr=%0d want 1/0", ram_ren, raddr); end
    n_cmp++; if (count !== 8'd1) begin n_bad++; $display("FAIL single_count1: got %0d want 1", count); end
    step(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early2: got %b want 0", out_valid); end
    step(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early3: got %b want 0", out_valid); end
    step(); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid4: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== dval(0)) begin n_bad++; $display("FAIL single_data: got %h want %h", out_data, dval(0)); end
    n_cmp++; if (count !== 8'd1) begin n_bad++; $display("FAIL single_count4: got %0d want 1", count); end
    out_ready = 1'b1;
    step(); out_ready = 1'b0; #1;
    n_cmp++; if ({out_valid, empty, count} !== {1'b0, 1'b1, 8'd0}) begin n_bad++; $display("FAIL single_pop: got v=%b e=%b c=%0d want 0/1/0", out_valid, empty, count); end
  endtask

  task automatic test_full();
    int idx;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = dval(100 + i); #1;
      n_cmp++; if ({ram_wen, waddr} !== {1'b1, AW'(i)}) begin n_bad++; $display("FAIL fill_wr%0d: got wen=%b addr=%0d want 1/%0d", i, ram_wen, waddr, i); end
      step();
    end
    in_valid = 1'b1; in_data = dval(999); #1;
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", full); end
    n_cmp++; if (count !== 8'd128) begin n_bad++; $display("FAIL full_count: got %0d want 128", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
    n_cmp++; if (ram_wen !== 1'b0) begin n_bad++; $display("FAIL full_overwrite: got %b want 0", ram_wen); end
    step(); in_valid = 1'b0; out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 800 && idx < DEPTH; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        n_cmp++; if (out_data !== dval(100 + idx)) begin n_bad++; $display("FAIL drain%0d: got %h want %h", idx, out_data, dval(100 + idx)); end
        idx++;
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (idx !== DEPTH) begin n_bad++; $display("FAIL drain_timeout: got %0d pops want %0d", idx, DEPTH); end
    #1;
    n_cmp++; if ({empty, count} !== {1'b1, 8'd0}) begin n_bad++; $display("FAIL drain_empty: got e=%b c=%0d want 1/0", empty, count); end
    in_valid = 1'b1; in_data = dval(500); #1;
    n_cmp++; if ({ram_wen, waddr} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL wrap_wr: got wen=%b addr=%0d want 1/0", ram_wen, waddr); end
    step(); in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit got;
    do_reset();
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = dval(10 + i); step(); end
    in_valid = 1'b0;
    wait_valid(20, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_wait1: got %b want 1", got); end
    n_cmp++; if (count !== 8'd5) begin n_bad++; $display("FAIL b2b_count_pre: got %0d want 5", count); end
    n_cmp++; if (out_data !== dval(10)) begin n_bad++; $display("FAIL b2b_data0: got %h want %h", out_data, dval(10)); end
    in_valid = 1'b1; in_data = dval(15); out_ready = 1'b1;
    step(); in_valid = 1'b0; out_ready = 1'b0; #1;
    n_cmp++; if (count !== 8'd5) begin n_bad++; $display("FAIL b2b_count_post: got %0d want 5", count); end
    wait_valid(20, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_wait2: got %b want 1", got); end
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if ({out_valid, out_data} !== {1'b1, dval(11)}) begin n_bad++; $display("FAIL stall%0d: got v=%b %h want 1 %h", i, out_valid, out_data, dval(11)); end
      step();
    end
  endtask

  task automatic test_flush();
    bit got;
    do_reset();
    for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = dval(20 + i); step(); end
    in_valid = 1'b0; #1;
    n_cmp++; if (count !== 8'd3) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    FLUSH = 1'b1; in_valid = 1'b1; #1;
    n_cmp++; if ({in_ready, ram_wen} !== 2'b00) begin n_bad++; $display("FAIL flush_ready: got rdy=%b wen=%b want 0/0", in_ready, ram_wen); end
    step(); FLUSH = 1'b0; in_valid = 1'b0; #1;
    n_cmp++; if ({count, empty} !== {8'd0, 1'b1}) begin n_bad++; $display("FAIL flush_count: got c=%0d e=%b want 0/1", count, empty); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({out_valid, ram_ren} !== 2'b00) begin n_bad++; $display("FAIL flush_quiet%0d: got v=%b ren=%b want 0/0", i, out_valid, ram_ren); end
      step();
    end
    in_valid = 1'b1; in_data = dval(30); #1;
    n_cmp++; if ({ram_wen, waddr} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL flush_wr: got wen=%b addr=%0d want 1/0", ram_wen, waddr); end
    step(); in_valid = 1'b0; #1;
    n_cmp++; if ({ram_ren, raddr} !== {1'b1, 7'd0}) begin n_bad++; $display("FAIL flush_rd: got ren=%b addr=%0d want 1/0", ram_ren, raddr); end
    wait_valid(10, got);
    n_cmp++; if ({got, out_data} !== {1'b1, dval(30)}) begin n_bad++; $display("FAIL flush_data: got %b %h want 1 %h", got, out_data, dval(30)); end
  endtask

  task automatic test_err();
    bit got;
    do_reset();
    db_inject = 1'b1;
    for (int i = 0; i < 2; i++) begin in_valid = 1'b1; in_data = dval(40 + i); step(); end
    in_valid = 1'b0; db_inject = 1'b0;
    wait_valid(10, got);
    n_cmp++; if ({got, out_err} !== 2'b11) begin n_bad++; $display("FAIL err_set: got v=%b err=%b want 1/1", got, out_err); end
    n_cmp++; if (out_data !== dval(40)) begin n_bad++; $display("FAIL err_data0: got %h want %h", out_data, dval(40)); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wait_valid(10, got);
    n_cmp++; if ({got, out_err} !== 2'b10) begin n_bad++; $display("FAIL err_clear: got v=%b err=%b want 1/0", got, out_err); end
    n_cmp++; if (out_data !== dval(41)) begin n_bad++; $display("FAIL err_data1: got %h want %h", out_data, dval(41)); end
  endtask

  task automatic test_async_reset();
    bit got;
    do_reset();
    in_valid = 1'b1; in_data = dval(50); step(); in_valid = 1'b0;
    wait_valid(10, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL arst_hold: got %b want 1", got); end
    #2 RESET_N = 1'b0; #1;
    n_cmp++; if ({out_valid, out_err, ram_wen, ram_ren, full} !== 5'b00000) begin n_bad++; $display("FAIL arst_flags: got v=%b err=%b wen=%b ren=%b full=%b want 0", out_valid, out_err, ram_wen, ram_ren, full); end
    n_cmp++; if ({count, empty, in_ready} !== {8'd0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL arst_count: got c=%0d e=%b rdy=%b want 0/1/1", count, empty, in_ready); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL arst_data: got %h want 0", out_data); end
    step(); RESET_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dma_dsc_cache_ctrl.md
# dma_dsc_cache_ctrl

Descriptor cache controller for the DMA controller. It accepts fetched descriptors on a valid/ready stream and writes them into the descriptor cache SRAM as a circular FIFO. It reads them back in order, absorbs the SRAM's registered read latency, and presents one descriptor at a time to the channel engine on a second valid/ready stream. It sits between the descriptor fetch unit, upstream, and the channel engine, downstream, and drives the cache RAM wrapper directly.

## Interface
- WIDTH, 128, descriptor width in bits.
- DEPTH, 128, cache entries; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 7, RAM address width.
- RD_LATENCY, 2, cycles from RAM_REN to valid RAM_RDATA (address and data registers enabled).

Ports:
- CLOCK  in  1  single clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of all cached descriptors.
- DSC_IN_VALID  in  1  upstream descriptor valid.
- DSC_IN_READY  out  1  controller can accept a descriptor.
- DSC_IN_DATA  in  WIDTH  upstream descriptor.
- DSC_OUT_VALID  out  1  descriptor presented to the channel engine.
- DSC_OUT_READY  in  1  channel engine accepts the descriptor.
- DSC_OUT_DATA  out  WIDTH  descriptor, registered.
- DSC_OUT_ERR  out  1  RAM double-bit detect captured with DSC_OUT_DATA.
- COUNT  out  ADDR_WIDTH+1  number of entries held, including the one in flight or presented.
- FULL / EMPTY  out  1 each  COUNT==DEPTH / COUNT==0.
- RAM_WEN, RAM_WADDR[ADDR_WIDTH], RAM_WDATA[WIDTH]  out  write port to the cache RAM.
- RAM_REN, RAM_RADDR[ADDR_WIDTH]  out  read port to the cache RAM.
- RAM_RDATA  in  WIDTH  RAM read data.
- RAM_DB_DETECT  in  1  RAM double-bit error flag.

## Operation
- Write side:
  - DSC_IN_READY = !FULL & !FLUSH (combinational).
  - A write occurs on DSC_IN_VALID & DSC_IN_READY: RAM_WEN=1, RAM_WADDR=wr_ptr, RAM_WDATA=DSC_IN_DATA in the same cycle; then wr_ptr++.
- Read FSM states:
  - IDLE: if pending = COUNT − (entry held ? 1 : 0) > 0, assert RAM_REN=1 with RAM_RADDR=rd_ptr, increment rd_ptr, load the latency counter, and go to WAIT.
  - WAIT: count down RD_LATENCY cycles. In the cycle RAM_RDATA is valid, capture RAM_RDATA into DSC_OUT_DATA and RAM_DB_DETECT into DSC_OUT_ERR, then go to HOLD.
  - HOLD: DSC_OUT_VALID=1. On DSC_OUT_READY, pop (COUNT−1) and return to IDLE.
- RAM_REN is 0 in every cycle without an issue.
- The slot is freed only at the output handshake, so a write can never hit an address with a read in flight.
- COUNT update per cycle: +1 on write, −1 on pop, unchanged if both occur in the same cycle.
- Pointers wrap DEPTH−1 → 0 by natural overflow.
- FLUSH (priority over everything):
  - Next cycle: wr_ptr = rd_ptr = COUNT = 0, state = IDLE, DSC_OUT_VALID = 0, DSC_OUT_ERR = 0.
  - Any in-flight read data is discarded.
  - No write is performed during FLUSH (READY=0).
  - A handshake coincident with FLUSH is void.
- Reset: all registers are 0. Outputs are then DSC_OUT_VALID=0, DSC_OUT_DATA=0, DSC_OUT_ERR=0, COUNT=0, EMPTY=1, FULL=0, RAM_WEN=0, RAM_REN=0, and DSC_IN_READY=1 (FLUSH low). Reset mid-read abandons the read.

## Timing
- Write to RAM is zero-latency: the write takes effect on the same edge as the handshake.
- Issue in cycle T → RAM_RDATA sampled at the end of cycle T+RD_LATENCY → DSC_OUT_VALID high from T+RD_LATENCY+1.
- Empty case: a write at T updates COUNT at T+1 and the issue happens at T+1. DSC_OUT_VALID rises at T+4 (RD_LATENCY=2).
- Pop at cycle H → IDLE at H+1 → next issue at H+1 if pending. Sustained throughput is one descriptor per RD_LATENCY+2 cycles.
- While DSC_OUT_VALID=1 and DSC_OUT_READY=0, DSC_OUT_DATA and DSC_OUT_ERR hold stable.
- FULL/EMPTY/COUNT are registered and reflect the state after the previous edge.

## Test plan
- Reset, then write D0 at cycle 0 → RAM_WEN=1, WADDR=0 at cycle 0; RAM_REN=1, RADDR=0 at cycle 1; DSC_OUT_VALID=1 with data D0 at cycle 4; COUNT=1 until pop.
- Hold DSC_OUT_READY=0 and write 128 descriptors → FULL=1, COUNT=128, DSC_IN_READY=0. A 129th offered write causes no RAM_WEN. Drain all → data emerges in order D0..D127, EMPTY=1, and the next write lands at WADDR=0 (wrap).
- With COUNT=5, write and pop in the same cycle → COUNT stays 5; stall READY for 10 cycles → DSC_OUT_DATA is unchanged.
- Assert FLUSH in the WAIT state with COUNT=3 → next cycle COUNT=0, DSC_OUT_VALID stays 0 even after the RAM data returns, and a following write reads back at address 0.
- Drive RAM_DB_DETECT=1 in the capture cycle → DSC_OUT_ERR=1 alongside that descriptor. The next descriptor, captured without the error, shows DSC_OUT_ERR=0.
- Assert RESET_N=0 asynchronously mid-HOLD → DSC_OUT_VALID drops immediately and all outputs take their reset values.
